// File: rtl/omem_burst_if.sv
// omem_burst_if: bus bundle for the omem_burst output memory.
//   Write port     : wr, waddr, in
//   Random read    : rd, raddr -> out, out_vld
//   Burst drain    : bst_start, bst_base, bst_len -> bst_data, bst_valid,
//                    bst_ready (downstream accept), busy, done
//   slave modport  : the memory side; master modport: the driver side.
interface omem_burst_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 7
);
  logic             wr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] in;
  logic             rd;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] out;
  logic             out_vld;
  logic             bst_start;
  logic [AW-1:0]    bst_base;
  logic [AW:0]      bst_len;
  logic [WIDTH-1:0] bst_data;
  logic             bst_valid;
  logic             bst_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  wr, waddr, in, rd, raddr, bst_start, bst_base, bst_len, bst_ready,
    output out, out_vld, bst_data, bst_valid, busy, done
  );

  modport master (
    output wr, waddr, in, rd, raddr, bst_start, bst_base, bst_len, bst_ready,
    input  out, out_vld, bst_data, bst_valid, busy, done
  );
endinterface

// File: rtl/omem_burst.sv
// omem_burst: WIDTH x DEPTH output memory with a 1-cycle random read port and
// a burst drain engine streaming a wrapping address range over valid/ready.
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-high reset (memory contents are kept)
//   bus     : omem_burst_if.slave (write, random read, burst drain signals)
// Optional feature macro: OMEM_CLEAR_ON_DRAIN_EN -- each burst-read word is
// zeroed in the same cycle it is read (read returns the pre-clear value).
module omem_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic         i_clock,
  input  logic         i_reset,
  omem_burst_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, OUT, FIN} state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_addr;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_bst_data;
  logic             r_bst_valid;
  logic             r_busy;
  logic             r_done;

  logic [AW:0]      w_len;
  logic             w_rd_fire;
  logic             w_clear;

  always_comb begin
    w_len = (bus.bst_len > LP_DEPTH) ? LP_DEPTH : bus.bst_len;
`ifdef OMEM_CLEAR_ON_DRAIN_EN
    // An external write owns the write port, so the read+clear waits a cycle.
    w_rd_fire = (r_state == RD) && !bus.wr;
    w_clear   = w_rd_fire;
`else
    w_rd_fire = (r_state == RD);
    w_clear   = 1'b0;
`endif
  end

  // Storage: no reset. Nonblocking update gives read-before-write on both ports.
  always_ff @(posedge i_clock) begin
    if (bus.wr) begin
      r_mem[bus.waddr] <= bus.in;
    end else if (w_clear) begin
      r_mem[r_addr] <= '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_vld   <= 1'b0;
      r_bst_data  <= '0;
      r_bst_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      r_done    <= 1'b0;

      // Random port only while the engine does not own the read port.
      if (bus.rd && !r_busy) begin
        r_out     <= r_mem[bus.raddr];
        r_out_vld <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (bus.bst_start) begin
            if (w_len != '0) begin
              r_addr  <= bus.bst_base;
              r_cnt   <= w_len;
              r_busy  <= 1'b1;
              r_state <= RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        RD: begin
          if (w_rd_fire) begin
            r_bst_data  <= r_mem[r_addr];
            r_bst_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (bus.bst_ready) begin
            r_bst_valid <= 1'b0;
            r_addr      <= r_addr + AW'(1);
            r_cnt       <= r_cnt - (AW+1)'(1);
            if (r_cnt == (AW+1)'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_state <= RD;
            end
          end
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_vld   = r_out_vld;
  assign bus.bst_data  = r_bst_data;
  assign bus.bst_valid = r_bst_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_omem_burst.sv
// tb_omem_burst: self-checking bench for omem_burst against a plain array
// model of the memory and a queue-based model of each burst's stream.
module tb_omem_burst;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  omem_burst_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  omem_burst #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] exp_q[$];

  int unsigned rb_first, rb_spacing_bad, rb_unstable, rb_done_cnt, rb_rd_leak;
  int unsigned rb_done_cyc, rb_last_hs, rb_stalls;
  bit          rb_timeout;
  logic        rb_busy_at_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr = 1'b0; bus.waddr = '0; bus.in = '0;
    bus.rd = 1'b0; bus.raddr = '0;
    bus.bst_start = 1'b0; bus.bst_base = '0; bus.bst_len = '0; bus.bst_ready = 1'b0;
  endtask

  task automatic mem_write(input int unsigned a, input logic [WIDTH-1:0] d);
    bus.wr = 1'b1; bus.waddr = AW'(a); bus.in = d;
    tick();
    bus.wr = 1'b0;
    model[a] = d;
  endtask

  task automatic mem_read(input int unsigned a);
    bus.rd = 1'b1; bus.raddr = AW'(a);
    tick();
    bus.rd = 1'b0;
  endtask

  // Reference stream: contiguous wrapping range, length clamped to DEPTH.
  task automatic model_burst(input int unsigned base, input int unsigned len);
    int unsigned n;
    n = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back(model[(base + i) % DEPTH]);
`ifdef OMEM_CLEAR_ON_DRAIN_EN
      model[(base + i) % DEPTH] = '0;
`endif
    end
  endtask

  // Drives one burst and records observations; comparisons live in the tests.
  task automatic run_burst(input int unsigned base, input int unsigned len,
                           input int unsigned ready_pct, input int unsigned stall_word,
                           input bit rd_during);
    int unsigned cyc, budget;
    bit pv, pr, done_seen, rdy;
    logic [WIDTH-1:0] pd, saved_out;
    got_q.delete();
    rb_first = 0; rb_spacing_bad = 0; rb_unstable = 0; rb_done_cnt = 0;
    rb_rd_leak = 0; rb_done_cyc = 0; rb_last_hs = 0; rb_stalls = 0;
    saved_out = bus.out;
    bus.bst_base = AW'(base); bus.bst_len = (AW+1)'(len); bus.bst_start = 1'b1;
    tick();
    bus.bst_start = 1'b0;
    cyc = 1; budget = 8 * len + 40; pv = 0; pr = 0; pd = '0; done_seen = 0;
    while (!done_seen && cyc < budget) begin
      if (bus.done === 1'b1) begin
        rb_done_cnt++; rb_done_cyc = cyc; done_seen = 1;
      end
      if (bus.bst_valid === 1'b1 && pv && !pr && bus.bst_data !== pd) rb_unstable++;
      if (rd_during) begin
        if (bus.out_vld !== 1'b0 || bus.out !== saved_out) rb_rd_leak++;
        bus.rd = bus.busy; bus.raddr = AW'($urandom);
      end
      if (got_q.size() == stall_word && rb_stalls < 5) rdy = 0;
      else rdy = ($urandom_range(99) < ready_pct);
      if (bus.bst_valid === 1'b1 && !rdy && got_q.size() == stall_word) rb_stalls++;
      bus.bst_ready = rdy;
      if (bus.bst_valid === 1'b1 && rdy) begin
        if (got_q.size() == 0) rb_first = cyc;
        else if (cyc - rb_last_hs != 2) rb_spacing_bad++;
        got_q.push_back(bus.bst_data);
        rb_last_hs = cyc;
      end
      pv = (bus.bst_valid === 1'b1); pr = rdy; pd = bus.bst_data;
      if (!done_seen) begin
        tick(); cyc++;
      end
    end
    rb_timeout = !done_seen;
    rb_busy_at_done = bus.busy;
    bus.bst_ready = 1'b0; bus.rd = 1'b0;
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) rb_done_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (bus.out !== '0)         begin failures++; $display("FAIL reset_out: got %0h expected 0", bus.out); end
    checks++; if (bus.out_vld !== 1'b0)   begin failures++; $display("FAIL reset_out_vld: got %0b expected 0", bus.out_vld); end
    checks++; if (bus.bst_data !== '0)    begin failures++; $display("FAIL reset_bst_data: got %0h expected 0", bus.bst_data); end
    checks++; if (bus.bst_valid !== 1'b0) begin failures++; $display("FAIL reset_bst_valid: got %0b expected 0", bus.bst_valid); end
    checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_random_read();
    int unsigned a;
    mem_write(5, 8'hA5);
    mem_read(5);
    checks++; if (bus.out !== 8'hA5)    begin failures++; $display("FAIL rd5_data: got %0h expected a5", bus.out); end
    checks++; if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL rd5_vld: got %0b expected 1", bus.out_vld); end
    tick();
    checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL rd5_vld_pulse: got %0b expected 0", bus.out_vld); end
    checks++; if (bus.out !== 8'hA5)    begin failures++; $display("FAIL rd5_hold: got %0h expected a5", bus.out); end
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(DEPTH - 1);
      mem_write(a, WIDTH'($urandom));
      mem_read(a);
      checks++; if (bus.out !== model[a]) begin failures++; $display("FAIL rand_read a=%0d: got %0h expected %0h", a, bus.out, model[a]); end
    end
  endtask

  task automatic test_read_during_write();
    mem_write(9, 8'h11);
    bus.wr = 1'b1; bus.waddr = 9; bus.in = 8'h33;
    bus.rd = 1'b1; bus.raddr = 9;
    tick();
    bus.wr = 1'b0; bus.rd = 1'b0;
    model[9] = 8'h33;
    checks++; if (bus.out !== 8'h11) begin failures++; $display("FAIL rdw_old: got %0h expected 11", bus.out); end
    mem_read(9);
    checks++; if (bus.out !== 8'h33) begin failures++; $display("FAIL rdw_new: got %0h expected 33", bus.out); end
  endtask

  task automatic test_wrap_burst();
    for (int unsigned i = 0; i < DEPTH; i++) mem_write(i, WIDTH'(i));
    model_burst(DEPTH - 2, 4);
    run_burst(DEPTH - 2, 4, 100, DEPTH + 1, 0);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL wrap_count: got %0d expected 4", got_q.size()); end
    for (int unsigned i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rb_first != 2)       begin failures++; $display("FAIL wrap_latency: got %0d expected 2", rb_first); end
    checks++; if (rb_spacing_bad != 0) begin failures++; $display("FAIL wrap_throughput: got %0d bad gaps expected 0", rb_spacing_bad); end
    checks++; if (rb_timeout)          begin failures++; $display("FAIL wrap_timeout: got timeout expected done"); end
    checks++; if (rb_done_cnt != 1)    begin failures++; $display("FAIL wrap_done_count: got %0d expected 1", rb_done_cnt); end
    checks++; if (rb_done_cyc != rb_last_hs + 1) begin failures++; $display("FAIL wrap_done_time: got %0d expected %0d", rb_done_cyc, rb_last_hs + 1); end
    checks++; if (rb_busy_at_done !== 1'b0) begin failures++; $display("FAIL wrap_busy_fin: got %0b expected 0", rb_busy_at_done); end
  endtask

  task automatic test_backpressure();
    int unsigned base, bad;
    base = $urandom_range(DEPTH - 1);
    for (int unsigned i = 0; i < 3; i++) mem_write((base + i) % DEPTH, WIDTH'($urandom));
    model_burst(base, 3);
    run_burst(base, 3, 100, 1, 0);
    bad = 0;
    for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL bp_handshakes: got %0d expected 3", got_q.size()); end
    checks++; if (bad != 0)          begin failures++; $display("FAIL bp_words: got %0d wrong expected 0", bad); end
    checks++; if (rb_stalls != 5)    begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", rb_stalls); end
    checks++; if (rb_unstable != 0)  begin failures++; $display("FAIL bp_stable: got %0d changes expected 0", rb_unstable); end
    checks++; if (rb_done_cnt != 1)  begin failures++; $display("FAIL bp_done: got %0d expected 1", rb_done_cnt); end
  endtask

  task automatic test_len0_and_busy_read();
    int unsigned bad;
    run_burst(7, 0, 100, DEPTH + 1, 0);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL len0_words: got %0d expected 0", got_q.size()); end
    checks++; if (rb_done_cyc != 1)  begin failures++; $display("FAIL len0_done_time: got %0d expected 1", rb_done_cyc); end
    checks++; if (rb_done_cnt != 1)  begin failures++; $display("FAIL len0_done_count: got %0d expected 1", rb_done_cnt); end
    model_burst(20, 8);
    run_burst(20, 8, 100, DEPTH + 1, 1);
    bad = 0;
    for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (rb_rd_leak != 0)   begin failures++; $display("FAIL busy_read_ignored: got %0d leaks expected 0", rb_rd_leak); end
    checks++; if (got_q.size() != 8 || bad != 0) begin failures++; $display("FAIL busy_read_stream: got %0d words %0d wrong expected 8 words 0 wrong", got_q.size(), bad); end
  endtask

  task automatic test_mid_burst_reset();
    int unsigned dones;
    for (int unsigned i = 0; i < 8; i++) mem_write(40 + i, WIDTH'(8'h80 | i));
    bus.bst_base = 40; bus.bst_len = 8; bus.bst_start = 1'b1; bus.bst_ready = 1'b1;
    tick();
    bus.bst_start = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %0b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.bst_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %0b expected 0", bus.bst_valid); end
    checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.bst_data !== '0 || bus.out !== '0 || bus.out_vld !== 1'b0 || bus.done !== 1'b0)
      begin failures++; $display("FAIL midrst_outputs: got data=%0h out=%0h vld=%0b done=%0b expected all 0", bus.bst_data, bus.out, bus.out_vld, bus.done); end
    #2 rst = 1'b0;
    dones = 0;
    repeat (5) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    bus.bst_ready = 1'b0;
    checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
  endtask

`ifdef OMEM_CLEAR_ON_DRAIN_EN
  task automatic test_clear_on_drain();
    int unsigned base, bad;
    base = $urandom_range(DEPTH - 1);
    for (int unsigned i = 0; i < 4; i++) mem_write((base + i) % DEPTH, WIDTH'($urandom_range(255, 1)));
    model_burst(base, 4);
    run_burst(base, 4, 100, DEPTH + 1, 0);
    bad = 0;
    for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (got_q.size() != 4 || bad != 0) begin failures++; $display("FAIL clear_stream: got %0d words %0d wrong expected 4 words 0 wrong", got_q.size(), bad); end
    for (int unsigned i = 0; i < 4; i++) begin
      mem_read((base + i) % DEPTH);
      checks++; if (bus.out !== model[(base + i) % DEPTH]) begin failures++; $display("FAIL clear_readback%0d: got %0h expected %0h", i, bus.out, model[(base + i) % DEPTH]); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned base, len, bad;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 8; w++) mem_write($urandom_range(DEPTH - 1), WIDTH'($urandom));
      base = $urandom_range(DEPTH - 1);
      len  = (k == 0) ? DEPTH : (k == 1) ? 200 : $urandom_range(20, 1);
      model_burst(base, len);
      run_burst(base, len, 70, DEPTH + 1, 0);
      bad = 0;
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b%0d_count: got %0d expected %0d", k, got_q.size(), exp_q.size()); end
      checks++; if (bad != 0)         begin failures++; $display("FAIL b2b%0d_words: got %0d wrong expected 0", k, bad); end
      checks++; if (rb_timeout || rb_done_cnt != 1) begin failures++; $display("FAIL b2b%0d_done: got timeout=%0b count=%0d expected 0/1", k, rb_timeout, rb_done_cnt); end
      checks++; if (rb_unstable != 0) begin failures++; $display("FAIL b2b%0d_stable: got %0d expected 0", k, rb_unstable); end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_random_read();
    test_read_during_write();
    test_wrap_burst();
    test_backpressure();
    test_len0_and_busy_read();
    test_mid_burst_reset();
`ifdef OMEM_CLEAR_ON_DRAIN_EN
    test_clear_on_drain();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/omem_burst.md
Name: omem_burst

Overview:
- Parametrised output memory block; next generation of the 8-bit x 128 output memory.
- Holds result words written by the compute datapath.
- Two ways to read: a random-access read port (1-cycle latency), and a burst drain engine that streams a contiguous, wrapping address range out over a valid/ready interface to the downstream output serializer.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 128, number of words; must be a power of two.
- AW, 7, address width; must equal log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr  in  1  write strobe.
- waddr  in  AW  write address.
- in  in  WIDTH  write data.
- rd  in  1  random read strobe.
- raddr  in  AW  random read address.
- out  out  WIDTH  random read data.
- out_vld  out  1  random read data valid.
- bst_start  in  1  burst start pulse.
- bst_base  in  AW  first burst address.
- bst_len  in  AW+1  number of words to stream, 0..DEPTH.
- bst_data  out  WIDTH  streamed word.
- bst_valid  out  1  streamed word valid.
- bst_ready  in  1  downstream accepts word.
- busy  out  1  burst engine active.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; counters cleared. Memory contents are not reset.
- Write: on a clock edge with wr=1, memory[waddr] <= in. Writes are accepted in every state.
- Read-during-write to the same address returns the old data (read-before-write). This applies to both read paths.
- Random read: if rd=1 and busy=0, then out <= memory[raddr] and out_vld=1 on the next cycle.
  - out holds its value until the next accepted read.
  - out_vld is high for exactly one cycle per accepted read.
  - rd while busy=1 is ignored: out_vld stays 0 and out is unchanged.
- The burst engine owns the single memory read port whenever busy=1.
- FSM states: IDLE, RD, OUT, FIN.
  - IDLE: on bst_start with bst_len!=0, latch addr=bst_base and cnt=bst_len, then go to RD. busy=1 from the cycle after start.
  - IDLE: on bst_start with bst_len=0, go to FIN with no words streamed.
  - RD: issue a read of memory[addr], then go to OUT.
  - OUT: bst_data = read word and bst_valid=1. bst_data must stay stable while bst_valid=1 and bst_ready=0.
  - OUT on bst_ready=1: addr <= (addr+1) mod DEPTH and cnt <= cnt-1. If cnt was 1, go to FIN; otherwise go to RD.
  - FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Throughput: one word per 2 cycles when bst_ready is held high.
- Latency: start to first bst_valid is 2 cycles.
- bst_start while busy=1 or in FIN is ignored.
- Address wrap: base=DEPTH-2 with len=4 streams addresses DEPTH-2, DEPTH-1, 0, 1.
- bst_len=DEPTH streams every word exactly once. Values above DEPTH are clamped to DEPTH.
- Data written during a burst is seen by the burst only if the write lands before that word's RD cycle.
- Reset asserted mid-burst aborts immediately: bst_valid=0, busy=0, and no done pulse.

Optional Feature:
- Macro: OMEM_CLEAR_ON_DRAIN_EN.
- With the macro defined:
  - Each word is written to 0 in the RD cycle in which the burst reads it; the read returns the pre-clear value.
  - If wr=1 in that RD cycle, the engine stays in RD for that cycle: neither the read nor the clear is performed, and the external write proceeds. The engine retries on the next cycle.
  - Random reads never clear.
- Without the macro: burst reads are non-destructive, and wr has no effect on FSM timing.

Test Plan:
- Write addr 5 = 0xA5, then rd raddr=5 → next cycle out=0xA5, out_vld=1 for 1 cycle.
- Same cycle: wr addr 9 = 0x33 and rd addr 9, where addr 9 previously held 0x11 → out=0x11; a following read of addr 9 → 0x33.
- Fill addr i = i; burst base=126, len=4, bst_ready=1 → bst_data sequence 126, 127, 0, 1, one word per 2 cycles, then done pulse, busy=0.
- Burst len=3 with bst_ready low for 5 cycles on the 2nd word → bst_data is held stable, no word is lost or duplicated, exactly 3 handshakes occur.
- Burst len=0 → done pulse 1 cycle after start, bst_valid never high. rd during a len=8 burst → out_vld stays 0.
- Reset pulse mid-burst → all outputs 0 immediately, no done. With OMEM_CLEAR_ON_DRAIN_EN: after a len=4 burst, those 4 addresses read back 0, and data streamed during the burst equals the pre-burst values.
